year_countdown: RTL
===================

Name: year_countdown

Overview:
- Calendar down-counter: the reverse-direction companion to the team's year/leap-year up-counter.
- Loaded with a month/day/hh:mm:ss point and decremented one second per enabled tick, borrowing through minutes, hours, days and months with leap-aware February.
- Stops at Jan 01 00:00:00 (terminal) and pulses done.
- Used for "time remaining in year" displays and alarm countdowns.

Parameters:
- WRAP, 0: 0 = halt in DONE at terminal; 1 = pulse done, then continue from Dec 31 23:59:59 on the next enabled tick.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  one-second tick enable; one decrement per clk with en=1 in RUN
- leap  input  1  current year is a leap year (Feb = 29 days)
- load  input  1  load request, sampled each clk
- ld_month  input  4  load month, 1..12
- ld_day  input  5  load day, 1..days_in_month
- ld_hrs  input  5  load hours, 0..23
- ld_min  input  6  load minutes, 0..59
- ld_sec  input  6  load seconds, 0..59
- month  output  4  current month, 1..12
- day  output  5  current day
- hrs  output  5  current hours
- min  output  6  current minutes
- sec  output  6  current seconds
- running  output  1  high while state = RUN
- done  output  1  one-cycle pulse on reaching terminal
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Single clock; reset is synchronous and active-high on port rst.
- Reset (rst=1 at an edge; overrides load/en, including mid-run): month=1, day=1, hrs=min=sec=0, state IDLE, running=0, done=0, load_err=0.
- days_in_month(m): 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; for 2, 29 if leap else 28. Evaluated combinationally from the current leap input.
- States: IDLE, RUN, DONE. running = (state==RUN). All outputs are registered.
- Load check: valid iff 1<=ld_month<=12, 1<=ld_day<=days_in_month(ld_month), ld_hrs<=23, ld_min<=59, ld_sec<=59.
- Valid load in any state (priority over en) copies ld_* to the outputs at that edge.
  - If the loaded value is the terminal value: state DONE, done=1 for the following cycle.
  - Otherwise: state RUN.
- Invalid load: counters and state unchanged, load_err=1 for one cycle.
- Load latency: new values are visible the cycle after the load edge. The first decrement occurs at the next edge with en=1 and load=0.
- Decrement (RUN, en=1, load=0), applied at one edge:
  - sec>0: sec-1.
  - Otherwise sec=59, then borrow to min: if min>0, min-1; else min=59 and borrow to hrs.
  - hrs: if hrs>0, hrs-1; else hrs=23 and borrow to day.
  - day: if day>1, day-1; else borrow to month: month-1 and day=days_in_month(month-1) using current leap (Mar 1 -> Feb 29/28).
  - Terminal check: if the result equals Jan 01 00:00:00, state becomes DONE and done=1 during the cycle the terminal value is displayed.
- RUN with en=0: hold all values.
- IDLE and DONE: en ignored, values held.
- WRAP=1 in DONE with en=1: next value is Dec 31 23:59:59, state RUN, done=0.
- leap changing mid-run affects only future February entries; the current day is never clamped.
- load and en in the same cycle: load wins, no decrement that cycle.
- done and load_err never both high; done lasts exactly one cycle per terminal arrival.

Test Plan:
- Reset -> month=1, day=1, 00:00:00, running=0, done=0. Then assert rst mid-run at Jun 15 -> outputs return to reset values the next cycle.
- Load Mar 01 00:00:00 with leap=1, en=1 -> next value Feb 29 23:59:59. Repeat with leap=0 -> Feb 28 23:59:59. Load May 01 00:00:00 -> Apr 30 23:59:59.
- Load Jan 01 00:00:03, en held high -> sequence 02, 01, 00; done=1 exactly on the cycle showing 00:00:00; running drops; further en causes no change (WRAP=0). With WRAP=1 -> next value Dec 31 23:59:59, running=1.
- Invalid loads: Feb 30 (leap=1), Apr 31, month=13, hrs=24, sec=60 -> each gives a single load_err pulse, values and state unchanged. Feb 29 with leap=0 -> rejected; with leap=1 -> accepted.
- en toggled 1-0-1 from Dec 31 12:00:00 -> exactly 2 decrements, ending at 11:59:58. load asserted together with en -> loaded value appears with no decrement that cycle.
- Load Jan 01 00:00:00 -> state DONE with a done pulse next cycle and running stays 0. Reload Dec 31 23:59:59 -> running=1.

Source files
------------

// File: rtl/year_countdown.sv
// Calendar down-counter: month/day/hh:mm:ss decremented one second per tick,
// leap-aware month borrow, halts (or wraps to Dec 31) at Jan 01 00:00:00.
module year_countdown #(
  parameter bit WRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       leap,
  input  logic       load,
  input  logic [3:0] ld_month,
  input  logic [4:0] ld_day,
  input  logic [4:0] ld_hrs,
  input  logic [5:0] ld_min,
  input  logic [5:0] ld_sec,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic       w_ld_ok;
  logic       w_ld_term;
  logic       w_dec_term;
  logic [3:0] w_dec_month;
  logic [4:0] w_dec_day;
  logic [4:0] w_dec_hrs;
  logic [5:0] w_dec_min;
  logic [5:0] w_dec_sec;
  logic [3:0] w_month_nxt;
  logic [4:0] w_day_nxt;
  logic [4:0] w_hrs_nxt;
  logic [5:0] w_min_nxt;
  logic [5:0] w_sec_nxt;
  logic       w_done_nxt;
  logic       w_err_nxt;

  function automatic logic [4:0] dim(
    input logic [3:0] m,
    input logic       lp
  );
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = lp ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  endfunction

  always_comb begin
    w_ld_ok = (ld_month >= 4'd1) && (ld_month <= 4'd12)
           && (ld_day >= 5'd1) && (ld_day <= dim(ld_month, leap))
           && (ld_hrs <= 5'd23) && (ld_min <= 6'd59)
           && (ld_sec <= 6'd59);
    w_ld_term = (ld_month == 4'd1) && (ld_day == 5'd1)
             && (ld_hrs == 5'd0) && (ld_min == 6'd0)
             && (ld_sec == 6'd0);
  end

  // One-second decrement with borrow ripple through all fields
  always_comb begin
    w_dec_month = month;
    w_dec_day   = day;
    w_dec_hrs   = hrs;
    w_dec_min   = min;
    w_dec_sec   = sec;
    if (sec != 6'd0) begin
      w_dec_sec = sec - 6'd1;
    end else begin
      w_dec_sec = 6'd59;
      if (min != 6'd0) begin
        w_dec_min = min - 6'd1;
      end else begin
        w_dec_min = 6'd59;
        if (hrs != 5'd0) begin
          w_dec_hrs = hrs - 5'd1;
        end else begin
          w_dec_hrs = 5'd23;
          if (day > 5'd1) begin
            w_dec_day = day - 5'd1;
          end else begin
            w_dec_month = month - 4'd1;
            w_dec_day   = dim(month - 4'd1, leap);
          end
        end
      end
    end
    w_dec_term = (w_dec_month == 4'd1) && (w_dec_day == 5'd1)
              && (w_dec_hrs == 5'd0) && (w_dec_min == 6'd0)
              && (w_dec_sec == 6'd0);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_month_nxt = month;
    w_day_nxt   = day;
    w_hrs_nxt   = hrs;
    w_min_nxt   = min;
    w_sec_nxt   = sec;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (load) begin
      if (w_ld_ok) begin
        w_month_nxt = ld_month;
        w_day_nxt   = ld_day;
        w_hrs_nxt   = ld_hrs;
        w_min_nxt   = ld_min;
        w_sec_nxt   = ld_sec;
        w_state_nxt = w_ld_term ? S_DONE : S_RUN;
        w_done_nxt  = w_ld_term;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (en) begin
      case (r_state)
        S_RUN: begin
          w_month_nxt = w_dec_month;
          w_day_nxt   = w_dec_day;
          w_hrs_nxt   = w_dec_hrs;
          w_min_nxt   = w_dec_min;
          w_sec_nxt   = w_dec_sec;
          w_state_nxt = w_dec_term ? S_DONE : S_RUN;
          w_done_nxt  = w_dec_term;
        end
        S_DONE: begin
          if (WRAP) begin
            w_month_nxt = 4'd12;
            w_day_nxt   = 5'd31;
            w_hrs_nxt   = 5'd23;
            w_min_nxt   = 6'd59;
            w_sec_nxt   = 6'd59;
            w_state_nxt = S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      month    <= 4'd1;
      day      <= 5'd1;
      hrs      <= 5'd0;
      min      <= 6'd0;
      sec      <= 6'd0;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      month    <= w_month_nxt;
      day      <= w_day_nxt;
      hrs      <= w_hrs_nxt;
      min      <= w_min_nxt;
      sec      <= w_sec_nxt;
      running  <= (w_state_nxt == S_RUN);
      done     <= w_done_nxt;
      load_err <= w_err_nxt;
    end
  end

endmodule
